// File: rtl/mem_access_unit.sv
// mem_access_unit: executes LOAD/STORE/Load_Imm commands over a req/ack data-memory port
module mem_access_unit #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int IW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  input  logic          LOAD,
  input  logic          STORE,
  input  logic          Load_Imm,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] imm,
  output logic          busy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          done,
  output logic          err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state_q)
        IDLE: if (cmd_valid) begin
          if (STORE || LOAD) begin
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            mem_we    <= STORE;
            mem_addr  <= addr;
            mem_wdata <= wdata;
            cnt_q     <= '0;
            state_q   <= REQ;
          end else if (Load_Imm) begin
            rd_data  <= {{(DW-IW){1'b0}}, imm};
            rd_valid <= 1'b1;
            done     <= 1'b1;
          end
        end
        // an ack arriving on the timeout edge still completes the access
        REQ: if (mem_ack) begin
          mem_req <= 1'b0;
          if (!mem_we) rd_data <= mem_rdata;
          state_q <= RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          mem_req <= 1'b0;
          err     <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        RESP: begin
          done     <= 1'b1;
          rd_valid <= !mem_we;
          busy     <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, LOAD = 1'b0, STORE = 1'b0, Load_Imm = 1'b0;
  logic [15:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic [7:0]  imm = '0;
  logic        mem_ack = 1'b0;
  logic        busy, mem_req, mem_we, rd_valid, done, err;
  logic [15:0] mem_addr, mem_wdata, rd_data;
  int checks = 0, failures = 0;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .LOAD(LOAD), .STORE(STORE),
    .Load_Imm(Load_Imm), .addr(addr), .wdata(wdata), .imm(imm), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmd();
    cmd_valid = 1'b0; LOAD = 1'b0; STORE = 1'b0; Load_Imm = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({busy, mem_req, mem_we, rd_valid, done, err} !== 6'b0 || mem_addr !== 16'h0 ||
        mem_wdata !== 16'h0 || rd_data !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h rd=%h required all zero",
               {busy, mem_req, mem_we, rd_valid, done, err}, mem_addr, mem_wdata, rd_data);
    end
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    cmd_valid = 1'b1; LOAD = 1'b1; addr = 16'h0040;
    tick();
    clear_cmd();
    checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0040) begin
      failures++;
      $display("FAIL load_issue: req=%b busy=%b we=%b addr=%h required 1 1 0 0040", mem_req, busy, mem_we, mem_addr);
    end
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0;
    checks++;
    if (mem_req !== 1'b0 || rd_data !== 16'hBEEF || done !== 1'b0 || rd_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL load_ack: req=%b rd=%h done=%b rv=%b busy=%b required 0 beef 0 0 1", mem_req, rd_data, done, rd_valid, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || rd_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL load_done: done=%b rv=%b busy=%b required 1 1 0", done, rd_valid, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL load_pulse_width: done=%b rv=%b required 0 0", done, rd_valid);
    end
  endtask

  task automatic test_store();
    cmd_valid = 1'b1; STORE = 1'b1; addr = 16'h0010; wdata = 16'h1234;
    tick();
    clear_cmd();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 16'h1234) begin
      failures++;
      $display("FAIL store_issue: req=%b we=%b addr=%h wdata=%h required 1 1 0010 1234", mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL store_ack: req=%b done=%b required 0 0", mem_req, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 16'hBEEF || busy !== 1'b0) begin
      failures++;
      $display("FAIL store_done: done=%b rv=%b rd=%h busy=%b required 1 0 beef 0", done, rd_valid, rd_data, busy);
    end
    tick();
  endtask

  task automatic test_load_imm();
    logic [7:0]  imms [3] = '{8'hA5, 8'hA5, 8'h5A};
    logic [15:0] exps [3] = '{16'h00A5, 16'h00A5, 16'h005A};
    cmd_valid = 1'b1; Load_Imm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imm = imms[i];
      tick();
      checks++;
      if (rd_data !== exps[i] || rd_valid !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin
        failures++;
        $display("FAIL load_imm_%0d: rd=%h rv=%b done=%b busy=%b req=%b required %h 1 1 0 0",
                 i, rd_data, rd_valid, done, busy, mem_req, exps[i]);
      end
    end
    clear_cmd();
    tick();
    checks++;
    if (rd_valid !== 1'b0 || done !== 1'b0 || rd_data !== 16'h005A) begin
      failures++;
      $display("FAIL load_imm_idle: rv=%b done=%b rd=%h required 0 0 005a", rd_valid, done, rd_data);
    end
  endtask

  task automatic test_timeout();
    int held = 0;
    cmd_valid = 1'b1; LOAD = 1'b1; addr = 16'h0300;
    tick();
    clear_cmd();
    if (mem_req === 1'b1) held = 1;
    for (int i = 0; i < 40 && mem_req === 1'b1; i++) begin
      tick();
      if (mem_req === 1'b1) held++;
    end
    checks++;
    if (held != 15) begin
      failures++;
      $display("FAIL timeout_len: mem_req held %0d cycles required 15", held);
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 16'h005A) begin
      failures++;
      $display("FAIL timeout_abort: err=%b busy=%b done=%b rv=%b rd=%h required 1 0 0 0 005a", err, busy, done, rd_valid, rd_data);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err_pulse: err=%b required 0", err);
    end
  endtask

  task automatic test_priority_busy();
    cmd_valid = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL no_strobe: busy=%b done=%b rv=%b req=%b required 0 0 0 0", busy, done, rd_valid, mem_req);
    end
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    LOAD = 1'b1; STORE = 1'b1; Load_Imm = 1'b1; addr = 16'h0020; wdata = 16'h7777; imm = 8'h11;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 16'h0020 || rd_valid !== 1'b0 || rd_data !== 16'h005A) begin
      failures++;
      $display("FAIL priority_store: we=%b req=%b addr=%h rv=%b rd=%h required 1 1 0020 0 005a", mem_we, mem_req, mem_addr, rd_valid, rd_data);
    end
    STORE = 1'b0; Load_Imm = 1'b0; addr = 16'h0099; wdata = 16'h0;
    tick();
    checks++;
    if (mem_addr !== 16'h0020 || mem_we !== 1'b1 || mem_wdata !== 16'h7777 || busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_ignore: addr=%h we=%b wdata=%h busy=%b required 0020 1 7777 1", mem_addr, mem_we, mem_wdata, busy);
    end
    clear_cmd();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 16'h005A || mem_addr !== 16'h0020) begin
      failures++;
      $display("FAIL priority_done: done=%b rv=%b rd=%h addr=%h required 1 0 005a 0020", done, rd_valid, rd_data, mem_addr);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; LOAD = 1'b1; addr = 16'h0444;
    tick();
    clear_cmd();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || rd_data !== 16'h0 || mem_addr !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid: req=%b busy=%b rd=%h addr=%h required 0 0 0000 0000", mem_req, busy, rd_data, mem_addr);
    end
    #2 rst_n = 1'b1;
    cmd_valid = 1'b1; Load_Imm = 1'b1; imm = 8'h3C;
    tick();
    clear_cmd();
    checks++;
    if (rd_data !== 16'h003C || rd_valid !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: rd=%h rv=%b busy=%b req=%b required 003c 1 0 0", rd_data, rd_valid, busy, mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_load_imm();
    test_timeout();
    test_priority_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
